// File: rtl/mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_if
// Handshake and strobe bundle between the shift-add multiplier sequencer and
// its surroundings (system side: start/ready/busy/done/shifts, datapath side:
// load/psel/reg_en/shift_en plus the zflag/lsb_multiplier status bits).
//
//   start          system   -> sequencer  request a new multiplication
//   zflag          datapath -> sequencer  multiplier register is zero
//   lsb_multiplier datapath -> sequencer  current multiplier LSB
//   load           sequencer -> datapath  latch operands and sign
//   psel           sequencer -> datapath  0 = clear product, 1 = accumulate
//   reg_en         sequencer -> datapath  product register write enable
//   shift_en       sequencer -> datapath  shift multiplicand/multiplier
//   ready/busy/done sequencer -> system   status
//   shifts         sequencer -> system    shifts done in last/current op
//
// modport master : the sequencer itself.
// modport slave  : whatever drives start and the datapath status bits.
// -----------------------------------------------------------------------------
interface mult_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             zflag;
  logic             lsb_multiplier;
  logic             load;
  logic             psel;
  logic             reg_en;
  logic             shift_en;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] shifts;

  modport master (
    input  start, zflag, lsb_multiplier,
    output load, psel, reg_en, shift_en, ready, busy, done, shifts
  );

  modport slave (
    output start, zflag, lsb_multiplier,
    input  load, psel, reg_en, shift_en, ready, busy, done, shifts
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Sequencing controller for a shift-add signed multiplier datapath. After a
// start request it loads the operands (clearing the product), then walks the
// multiplier bit by bit: a one bit costs an ADD and a SHIFT cycle, a zero bit a
// single shift issued directly from RUN. The run ends after WIDTH shifts or,
// with EARLY_EXIT set, as soon as the remaining multiplier is zero.
//
// Parameters:
//   WIDTH      operand width, maximum number of shifts
//   CNT_W      shift counter width, 2**CNT_W must exceed WIDTH
//   EARLY_EXIT 1 = stop as soon as zflag is seen in RUN
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any operation silently
//   bus    mult_seq_ctrl_if master modport (start/status/strobes/shifts)
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic            clk,
  input logic            rst_n,
  mult_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;

  logic             run_term;
  logic             load;
  logic             psel;
  logic             reg_en;
  logic             shift_en;
  logic             ready;
  logic             busy;
  logic             done;

  // Termination outranks add/shift, which keeps the counter from ever
  // passing WIDTH.
  assign run_term = ((EARLY_EXIT != 0) && bus.zflag) || (count == CNT_MAX);

  // ---------------------------------------------------------------------------
  // State register and shift counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset puts the controller in a safe idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == S_LOAD) begin
        count <= '0;
      end else if (shift_en) begin
        count <= count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_LOAD;
      S_LOAD:  state_next = S_RUN;
      S_RUN: begin
        if (run_term) begin
          state_next = S_DONE;
        end else if (bus.lsb_multiplier) begin
          state_next = S_ADD;
        end
        // Zero bit: stay in RUN and shift.
      end
      S_ADD:   state_next = S_SHIFT;
      S_SHIFT: state_next = S_RUN;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Strobes come from the state register; only the RUN-state
  // zero-bit shift also looks at the datapath status bits, never at start.
  // ---------------------------------------------------------------------------
  always_comb begin
    load     = 1'b0;
    psel     = 1'b0;
    reg_en   = 1'b0;
    shift_en = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_LOAD: begin
        load   = 1'b1;
        reg_en = 1'b1;   // psel=0 clears the product
        busy   = 1'b1;
      end
      S_RUN: begin
        busy     = 1'b1;
        shift_en = !run_term && !bus.lsb_multiplier;
      end
      S_ADD: begin
        reg_en = 1'b1;
        psel   = 1'b1;
        busy   = 1'b1;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign bus.load     = load;
  assign bus.psel     = psel;
  assign bus.reg_en   = reg_en;
  assign bus.shift_en = shift_en;
  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.shifts   = count;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Directed bench for mult_seq_ctrl. Two controllers are built side by side:
// index 0 with EARLY_EXIT=1, index 1 with EARLY_EXIT=0. Each one drives a
// small behavioural unsigned shift-add datapath that returns zflag and
// lsb_multiplier. Per-cycle strobe traces use one letter per cycle:
//   L load, A add (reg_en & psel), S shift, D done, R busy w/o strobe, I idle.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int BUDGET = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_v    [2];
  logic [7:0]       a_v        [2];
  logic [7:0]       b_v        [2];
  logic             load_w     [2];
  logic             psel_w     [2];
  logic             reg_en_w   [2];
  logic             shift_en_w [2];
  logic             ready_w    [2];
  logic             busy_w     [2];
  logic             done_w     [2];
  logic [CNT_W-1:0] shifts_w   [2];
  logic [15:0]      prod_w     [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_u
    mult_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mult_seq_ctrl #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .EARLY_EXIT((g == 0) ? 1 : 0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    // Behavioural datapath: unsigned magnitudes are enough for sequencing.
    logic [15:0] mcand;
    logic [15:0] prod;
    logic [7:0]  mult;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mcand <= '0;
        prod  <= '0;
        mult  <= '0;
      end else begin
        if (bus.load) begin
          mcand <= {8'd0, a_v[g]};
          mult  <= b_v[g];
        end
        if (bus.reg_en) prod <= bus.psel ? prod + mcand : 16'd0;
        if (bus.shift_en) begin
          mcand <= mcand << 1;
          mult  <= mult >> 1;
        end
      end
    end

    assign bus.start          = start_v[g];
    assign bus.zflag          = (mult == 8'd0);
    assign bus.lsb_multiplier = mult[0];

    assign load_w[g]     = bus.load;
    assign psel_w[g]     = bus.psel;
    assign reg_en_w[g]   = bus.reg_en;
    assign shift_en_w[g] = bus.shift_en;
    assign ready_w[g]    = bus.ready;
    assign busy_w[g]     = bus.busy;
    assign done_w[g]     = bus.done;
    assign shifts_w[g]   = bus.shifts;
    assign prod_w[g]     = prod;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {load, psel, reg_en, shift_en, ready, busy, done}
  function automatic logic [6:0] pins(input int sel);
    return {load_w[sel], psel_w[sel], reg_en_w[sel], shift_en_w[sel],
            ready_w[sel], busy_w[sel], done_w[sel]};
  endfunction

  // Issue one start at an IDLE controller and observe until done.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input bit hold, output int lat, output logic [255:0] trace,
                        output int nload, output int ndone, output int nover);
    logic [7:0] c;
    a_v[sel] = a;
    b_v[sel] = b;
    lat = 0; trace = '0; nload = 0; ndone = 0; nover = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (load_w[sel])                         c = "L";
      else if (reg_en_w[sel] && psel_w[sel])   c = "A";
      else if (shift_en_w[sel])                c = "S";
      else if (done_w[sel])                    c = "D";
      else if (busy_w[sel])                    c = "R";
      else                                     c = "I";
      trace = {trace[247:0], c};
      if (load_w[sel]) nload++;
      if (done_w[sel]) ndone++;
      if (reg_en_w[sel] && shift_en_w[sel]) nover++;
      if (done_w[sel]) begin
        lat = n;
        break;
      end
    end
  endtask

  int          lat, nload, ndone, nover, seen;
  logic [255:0] tr;

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    a_v[0] = '0; a_v[1] = '0; b_v[0] = '0; b_v[1] = '0;

    // Reset values, sampled mid-reset away from any clock edge.
    #12;
    check("rst_pins_ee1", 256'(pins(0)), 256'(7'b0000100));
    check("rst_pins_ee0", 256'(pins(1)), 256'(7'b0000100));
    check("rst_shifts",   256'(shifts_w[0]), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplier 0 with early exit: minimum latency.
    run_op(0, 8'h03, 8'h00, 1'b0, lat, tr, nload, ndone, nover);
    check("zero_latency", 256'(lat), 256'(3));
    check("zero_trace",   tr, 256'("LRD"));
    check("zero_shifts",  256'(shifts_w[0]), 256'(0));
    check("zero_prod",    256'(prod_w[0]), 256'(0));

    // 3 x 5, early exit.
    run_op(0, 8'h03, 8'h05, 1'b0, lat, tr, nload, ndone, nover);
    check("ee1_latency", 256'(lat), 256'(10));
    check("ee1_trace",   tr, 256'("LRASSRASRD"));
    check("ee1_shifts",  256'(shifts_w[0]), 256'(3));
    check("ee1_prod",    256'(prod_w[0]), 256'(15));

    // 3 x 5, full WIDTH shifts; shifts holds in IDLE.
    run_op(1, 8'h03, 8'h05, 1'b0, lat, tr, nload, ndone, nover);
    check("ee0_latency", 256'(lat), 256'(15));
    check("ee0_trace",   tr, 256'("LRASSRASSSSSSRD"));
    check("ee0_prod",    256'(prod_w[1]), 256'(15));
    repeat (3) @(negedge clk);
    check("ee0_idle_shifts", 256'(shifts_w[1]), 256'(8));
    check("ee0_idle_pins",   256'(pins(1)), 256'(7'b0000100));

    // 3 x 0xFF, full WIDTH: eight ADD/SHIFT pairs.
    run_op(1, 8'h03, 8'hFF, 1'b0, lat, tr, nload, ndone, nover);
    check("ff_latency", 256'(lat), 256'(27));
    check("ff_trace",   tr, 256'("LRASRASRASRASRASRASRASRASRD"));
    check("ff_shifts",  256'(shifts_w[1]), 256'(8));
    check("ff_prod",    256'(prod_w[1]), 256'(765));
    check("ff_overlap", 256'(nover), 256'(0));

    // start held high through RUN/ADD/SHIFT/DONE: no extra load, one done,
    // one IDLE cycle, then LOAD again.
    run_op(0, 8'h03, 8'h05, 1'b1, lat, tr, nload, ndone, nover);
    check("hold_latency", 256'(lat), 256'(10));
    check("hold_nload",   256'(nload), 256'(1));
    check("hold_ndone",   256'(ndone), 256'(1));
    @(negedge clk);
    check("hold_idle_gap", 256'({ready_w[0], load_w[0]}), 256'(2'b10));
    @(negedge clk);
    check("hold_reload", 256'(load_w[0]), 256'(1));
    start_v[0] = 1'b0;
    seen = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (done_w[0]) begin
        seen = 1;
        break;
      end
    end
    check("hold_second_done", 256'(seen), 256'(1));
    check("hold_second_prod", 256'(prod_w[0]), 256'(15));

    // Asynchronous reset in the middle of an ADD cycle.
    a_v[0] = 8'h03; b_v[0] = 8'h05;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    seen = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (reg_en_w[0] && psel_w[0]) begin
        seen = 1;
        break;
      end
    end
    check("rst_reach_add", 256'(seen), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pins",   256'(pins(0)), 256'(7'b0000100));
    check("rst_async_shifts", 256'(shifts_w[0]), 256'(0));
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) seen++;
    end
    check("rst_no_done", 256'(seen), 256'(0));
    rst_n = 1'b1;

    // Normal operation after release: 7 x 3.
    run_op(0, 8'h07, 8'h03, 1'b0, lat, tr, nload, ndone, nover);
    check("post_rst_latency", 256'(lat), 256'(9));
    check("post_rst_trace",   tr, 256'("LRASRASRD"));
    check("post_rst_shifts",  256'(shifts_w[0]), 256'(2));
    check("post_rst_prod",    256'(prod_w[0]), 256'(21));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
